// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Per-register pending-write scoreboard raising ID-stage freeze on
//            RAW hazards or a full per-register counter, with a saturating
//            stall-cycle counter and a sticky retire-underflow error flag.
// Options  : WB_BYPASS_EN - a retiring write unblocks its readers in the same
//            cycle (write-through register file).
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_COUNT = 16,
    parameter int REG_W     = 4,
    parameter int DEPTH     = 2,
    parameter int STALL_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue_valid,
    input  logic               issue_wb_en,
    input  logic [REG_W-1:0]   issue_dest,
    input  logic [REG_W-1:0]   src1,
    input  logic [REG_W-1:0]   src2,
    input  logic               two_src,
    input  logic               wb_valid,
    input  logic [REG_W-1:0]   wb_dest,
    input  logic               flush,
    output logic               freeze,
    output logic [STALL_W-1:0] stall_cycles,
    output logic               err
);

    localparam int              c_cw   = $clog2(DEPTH + 1);
    localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    logic [c_cw-1:0]      r_cnt [REG_COUNT];
    logic [STALL_W-1:0]   r_stall;
    logic                 r_err;

    logic [REG_COUNT-1:0] w_src1_sel;
    logic [REG_COUNT-1:0] w_src2_sel;
    logic [REG_COUNT-1:0] w_dest_sel;
    logic [REG_COUNT-1:0] w_wb_sel;
    logic [REG_COUNT-1:0] w_pend;
    logic [REG_COUNT-1:0] w_full;
    logic [REG_COUNT-1:0] w_inc;
    logic [REG_COUNT-1:0] w_dec;
    logic [REG_COUNT-1:0] w_err_hit;

    logic                 w_hit_src1;
    logic                 w_hit_src2;
    logic                 w_hit_full;
    logic                 w_freeze;
    logic                 w_accept;
    logic                 w_retire;

    // Only registers below REG_COUNT get decode bits, so out-of-range
    // indices never match, never count and never look pending.
    genvar g;
    generate
        for (g = 0; g < REG_COUNT; g++) begin : g_reg
            localparam logic [REG_W-1:0] c_idx = REG_W'(g);

            assign w_src1_sel[g] = (src1 == c_idx);
            assign w_src2_sel[g] = (src2 == c_idx);
            assign w_dest_sel[g] = (issue_dest == c_idx);
            assign w_wb_sel[g]   = (wb_dest == c_idx);

`ifdef WB_BYPASS_EN
            assign w_pend[g] = (r_cnt[g] != '0)
                             & ~(wb_valid & w_wb_sel[g] & (r_cnt[g] == c_one));
            assign w_full[g] = (r_cnt[g] == c_full) & ~(wb_valid & w_wb_sel[g]);
`else
            assign w_pend[g] = (r_cnt[g] != '0);
            assign w_full[g] = (r_cnt[g] == c_full);
`endif

            assign w_inc[g]     = w_accept & w_dest_sel[g];
            assign w_dec[g]     = w_retire & w_wb_sel[g];
            assign w_err_hit[g] = w_dec[g] & (r_cnt[g] == '0);

            // Issue and retire on the same register cancel; a retire on an
            // empty counter leaves it at zero and only raises err.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt[g] <= '0;
                end else if (flush) begin
                    r_cnt[g] <= '0;
                end else if (w_inc[g] && !w_dec[g]) begin
                    r_cnt[g] <= r_cnt[g] + c_one;
                end else if (w_dec[g] && !w_inc[g] && (r_cnt[g] != '0)) begin
                    r_cnt[g] <= r_cnt[g] - c_one;
                end
            end
        end
    endgenerate

    assign w_hit_src1 = |(w_pend & w_src1_sel);
    assign w_hit_src2 = two_src & (|(w_pend & w_src2_sel));
    assign w_hit_full = issue_wb_en & (|(w_full & w_dest_sel));

    assign w_freeze = rst_n & issue_valid & (w_hit_src1 | w_hit_src2 | w_hit_full);
    assign w_accept = issue_valid & issue_wb_en & ~w_freeze & ~flush;
    assign w_retire = wb_valid & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (w_freeze && (r_stall != {STALL_W{1'b1}})) begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (|w_err_hit) begin
            r_err <= 1'b1;
        end
    end

    assign freeze       = w_freeze;
    assign stall_cycles = r_stall;
    assign err          = r_err;

endmodule
`default_nettype wire
